// File: rtl/riscv_mem_pkg.sv
// Shared types and default widths for the RV32 memory-port arbiter.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/riscv_arb_timer.sv
// Watchdog counter for the WAIT state. Clears on request, counts while
// enabled, and saturates at TIMEOUT so it never wraps.
module riscv_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_count;

  // Saturating up-counter with synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == CNT_MAX);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Arbiter sharing one external memory port between instruction fetch (IF)
// and load/store (D). One transaction outstanding at a time.
//
// Handshake: a requester holds req until it sees its gnt; gnt is asserted
// combinationally in the cycle memory raises mem_gnt. The response arrives
// as a 1-cycle rvalid pulse to the owner, one cycle after mem_rvalid.
//
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on
// ties (default is fixed D-over-IF priority).
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                err,
  output logic [1:0]          dbg_state
);

  arb_state_t          r_state;
  arb_state_t          w_next;
  arb_owner_t          r_owner;
  arb_owner_t          w_winner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_be;
  logic                r_if_rvalid;
  logic                r_d_rvalid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                w_any_req;
  logic                w_arb;
  logic                w_expired;
  logic                w_tmr_clr;
  logic                w_tmr_en;

  assign w_any_req = if_req | d_req;
  assign w_arb     = (r_state == IDLE) && w_any_req;

`ifdef MEM_ARB_RR_EN
  arb_owner_t r_last_win;

  // Remember who won the last arbitration; IF at reset so D wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_win <= OWN_IF;
    end else if (w_arb) begin
      r_last_win <= w_winner;
    end
  end

  // Round-robin: on a tie the side that lost last time wins.
  always_comb begin
    w_winner = OWN_IF;
    if (if_req && d_req) begin
      w_winner = (r_last_win == OWN_IF) ? OWN_D : OWN_IF;
    end else if (d_req) begin
      w_winner = OWN_D;
    end
  end
`else
  // Fixed priority: load/store beats fetch.
  always_comb begin
    w_winner = OWN_IF;
    if (d_req) begin
      w_winner = OWN_D;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; rvalid outside WAIT is stale and ignored.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next = REQ;
      REQ:     if (mem_gnt) w_next = WAIT;
      WAIT:    if (mem_rvalid || w_expired) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Latch the winning transaction so a dropped req cannot disturb it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner <= OWN_IF;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_arb) begin
      r_owner <= w_winner;
      if (w_winner == OWN_D) begin
        r_we    <= d_we;
        r_addr  <= d_addr;
        r_wdata <= d_wdata;
        r_be    <= d_be;
      end else begin
        r_we    <= 1'b0;
        r_addr  <= if_addr;
        r_wdata <= '0;
        r_be    <= '1;
      end
    end
  end

  // Register the response and route it to the owner; store acks carry zero data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      if ((r_state == WAIT) && mem_rvalid) begin
        if (r_owner == OWN_IF) begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= mem_rdata;
        end else begin
          r_d_rvalid <= 1'b1;
          r_d_rdata  <= r_we ? '0 : mem_rdata;
        end
      end
    end
  end

  assign w_tmr_clr = (r_state == REQ) && mem_gnt;
  assign w_tmr_en  = (r_state == WAIT);

  riscv_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (reset),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

  // Output decode from state and latched transaction.
  always_comb begin
    mem_req   = (r_state == REQ);
    mem_we    = mem_req ? r_we    : 1'b0;
    mem_addr  = mem_req ? r_addr  : '0;
    mem_wdata = mem_req ? r_wdata : '0;
    mem_be    = mem_req ? r_be    : '0;
    if_gnt    = mem_req && mem_gnt && (r_owner == OWN_IF);
    d_gnt     = mem_req && mem_gnt && (r_owner == OWN_D);
    busy      = (r_state != IDLE);
    err       = (r_state == WAIT) && w_expired && !mem_rvalid;
    dbg_state = r_state;
  end

  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with a response scoreboard.
// Define MEM_ARB_RR_EN for both RTL and bench to check round-robin ties.
module tb_riscv_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        err;
  logic [1:0]  dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] exp_q_if[$];
  logic [31:0] exp_q_d[$];

  riscv_mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_be       (d_be),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All outputs must read zero (reset state)
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},   32'(busy), 32'd0);
    chk({tag, "_memreq"}, {30'd0, mem_req, mem_we}, 32'd0);
    chk({tag, "_addr"},   mem_addr, 32'd0);
    chk({tag, "_gnt"},    {30'd0, if_gnt, d_gnt}, 32'd0);
    chk({tag, "_rvalid"}, {30'd0, if_rvalid, d_rvalid}, 32'd0);
    chk({tag, "_rdata"},  if_rdata | d_rdata, 32'd0);
    chk({tag, "_err"},    32'(err), 32'd0);
    chk({tag, "_state"},  32'(dbg_state), 32'd0);
  endtask

  // Memory-side driver: entered in REQ, completes one transaction and
  // checks the routed response against the scoreboard.
  task automatic serve(input bit own_d, input int gnt_wait, input logic [31:0] e_addr,
                       input bit e_we, input logic [31:0] e_wdata, input logic [3:0] e_be,
                       input logic [31:0] rd);
    logic [31:0] exp_v;
    for (int k = 0; k < gnt_wait; k++) begin
      chk("stall_req",  32'(mem_req), 32'd1);
      chk("stall_addr", mem_addr, e_addr);
      chk("stall_gnt",  {30'd0, if_gnt, d_gnt}, 32'd0);
      step();
    end
    chk("req_req",   32'(mem_req), 32'd1);
    chk("req_busy",  32'(busy), 32'd1);
    chk("req_state", 32'(dbg_state), 32'd1);
    chk("req_addr",  mem_addr, e_addr);
    chk("req_we",    32'(mem_we), 32'(e_we));
    chk("req_be",    32'(mem_be), 32'(e_be));
    if (e_we) chk("req_wdata", mem_wdata, e_wdata);
    chk("pre_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
    mem_gnt = 1'b1;
    #1;
    chk("gnt_owner", {30'd0, if_gnt, d_gnt}, own_d ? 32'd1 : 32'd2);
    if (own_d) d_req = 1'b0;
    else       if_req = 1'b0;
    step();
    mem_gnt = 1'b0;
    #1;
    chk("wait_req",   32'(mem_req), 32'd0);
    chk("wait_busy",  32'(busy), 32'd1);
    chk("wait_state", 32'(dbg_state), 32'd2);
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    if (own_d) exp_q_d.push_back(e_we ? 32'd0 : rd);
    else       exp_q_if.push_back(rd);
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    #1;
    chk("rsp_valid", {30'd0, if_rvalid, d_rvalid}, own_d ? 32'd1 : 32'd2);
    if (own_d) begin
      exp_v = (exp_q_d.size() > 0) ? exp_q_d.pop_front() : 32'hxxxx_xxxx;
      chk("rsp_d_rdata", d_rdata, exp_v);
    end else begin
      exp_v = (exp_q_if.size() > 0) ? exp_q_if.pop_front() : 32'hxxxx_xxxx;
      chk("rsp_if_rdata", if_rdata, exp_v);
    end
    chk("rsp_busy", 32'(busy), 32'd0);
  endtask

  task automatic drive_if(input logic [31:0] a);
    if_req  = 1'b1;
    if_addr = a;
  endtask

  task automatic drive_d(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_be    = be;
  endtask

  initial begin
    bit          side;
    bit          rwe;
    logic [31:0] raddr;
    logic [31:0] rwd;
    logic [3:0]  rbe;
    bit          rr_if_first;

    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #3;
    chk_zero("reset");
    step();
    step();
    reset = 1'b1;
    step();

    // 1: fetch only, zero-wait memory
    drive_if(32'h0000_0010);
    #1;
    chk("t1_idle_busy", 32'(busy), 32'd0);
    step();
    serve(1'b0, 0, 32'h0000_0010, 1'b0, 32'd0, 4'hF, 32'h0010_0093);
    step();
    chk("t1_pulse_end", {30'd0, if_rvalid, d_rvalid}, 32'd0);

    // 2: simultaneous fetch and load, D served first
    drive_d(1'b0, 32'h0000_0100, 32'd0, 4'hF);
    drive_if(32'h0000_0014);
    step();
    serve(1'b1, 0, 32'h0000_0100, 1'b0, 32'd0, 4'hF, 32'hCAFE_0001);
    step();
    serve(1'b0, 0, 32'h0000_0014, 1'b0, 32'd0, 4'hF, 32'h0000_0013);

    // Tie right after a D win: round-robin gives IF, fixed priority gives D
    drive_d(1'b0, 32'h0000_0104, 32'd0, 4'hF);
    step();
    serve(1'b1, 0, 32'h0000_0104, 1'b0, 32'd0, 4'hF, 32'h1111_2222);
    drive_d(1'b0, 32'h0000_0108, 32'd0, 4'hF);
    drive_if(32'h0000_0018);
`ifdef MEM_ARB_RR_EN
    rr_if_first = 1'b1;
`else
    rr_if_first = 1'b0;
`endif
    step();
    if (rr_if_first) begin
      serve(1'b0, 0, 32'h0000_0018, 1'b0, 32'd0, 4'hF, 32'h0000_0033);
      step();
      serve(1'b1, 0, 32'h0000_0108, 1'b0, 32'd0, 4'hF, 32'h3333_4444);
    end else begin
      serve(1'b1, 0, 32'h0000_0108, 1'b0, 32'd0, 4'hF, 32'h3333_4444);
      step();
      serve(1'b0, 0, 32'h0000_0018, 1'b0, 32'd0, 4'hF, 32'h0000_0033);
    end

    // 3: store returns zero data, IF side stays quiet
    drive_d(1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011);
    step();
    serve(1'b1, 0, 32'h0000_0200, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'h1234_5678);

    // 4: mem_gnt held off for 5 cycles in REQ
    drive_d(1'b0, 32'h0000_0300, 32'd0, 4'hF);
    step();
    serve(1'b1, 5, 32'h0000_0300, 1'b0, 32'd0, 4'hF, 32'h5555_AAAA);

    // Random single-requester traffic with random grant latency
    for (int i = 0; i < 6; i++) begin
      side  = 1'($urandom_range(0, 1));
      raddr = 32'($urandom_range(0, 1023)) << 2;
      rwd   = $urandom;
      rwe   = side ? 1'($urandom_range(0, 1)) : 1'b0;
      rbe   = side ? 4'($urandom_range(1, 15)) : 4'hF;
      if (side) drive_d(rwe, raddr, rwd, rbe);
      else      drive_if(raddr);
      step();
      serve(side, int'($urandom_range(0, 3)), raddr, rwe, rwd, rbe, $urandom);
    end

    // 5: watchdog abort after 4 cycles in WAIT, late rvalid ignored
    drive_d(1'b0, 32'h0000_0400, 32'd0, 4'hF);
    step();
    chk("t5_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    #1;
    d_req = 1'b0;
    step();
    mem_gnt = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t5_err_early", 32'(err), 32'd0);
      chk("t5_busy", 32'(busy), 32'd1);
      step();
    end
    chk("t5_err_pulse", 32'(err), 32'd1);
    chk("t5_no_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    step();
    chk("t5_err_clear", 32'(err), 32'd0);
    chk("t5_idle", 32'(dbg_state), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0_BAD0;
    step();
    mem_rvalid = 1'b0;
    #1;
    chk("t5_late_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    chk("t5_late_busy", 32'(busy), 32'd0);

    // 6: reset asserted in WAIT, then a stale response after release
    drive_if(32'h0000_0020);
    step();
    mem_gnt = 1'b1;
    #1;
    if_req = 1'b0;
    step();
    mem_gnt = 1'b0;
    #1;
    chk("t6_in_wait", 32'(dbg_state), 32'd2);
    #1;
    reset = 1'b0;
    #1;
    chk_zero("t6_async");
    step();
    reset = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BAD_F00D;
    step();
    mem_rvalid = 1'b0;
    #1;
    chk("t6_stale_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    chk("t6_stale_busy", 32'(busy), 32'd0);
    chk("t6_sb_empty", 32'(exp_q_if.size() + exp_q_d.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
